// File: rtl/scalable_mac_acc.sv
// scalable_mac_acc: four-lane precision-scalable signed MAC accumulator with valid/ready handshakes.
// Define SCALABLE_MAC_ACC_SATURATE_EN for saturating lane adds and a sticky ovf flag; otherwise adds wrap.
module scalable_mac_acc #(
   parameter int ACT_W = 8,
   parameter int WGT_W = 8,
   parameter int ACC_W = 20
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_last,
   input  logic [1:0]              prec,
   input  logic signed [ACT_W-1:0] act,
   input  logic [WGT_W-1:0]        wgt,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [4*ACC_W-1:0]      result,
   output logic                    ovf
);
   localparam int HW = WGT_W / 2;
   localparam int QW = WGT_W / 4;

   typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

   state_t                  state;
   logic [1:0]              mode_r;
   logic [1:0]              eff_mode;
   logic                    rdy_r;
   logic                    ovld_r;
   logic                    accept;
   logic                    vld_p1;
   logic signed [ACC_W-1:0] act_x;
   logic signed [ACC_W-1:0] wf;
   logic signed [ACC_W-1:0] wh      [2];
   logic signed [ACC_W-1:0] wq      [4];
   logic signed [ACC_W-1:0] prod_c  [4];
   logic signed [ACC_W-1:0] prod_p1 [4];
   logic signed [ACC_W-1:0] acc_p2  [4];

`ifdef SCALABLE_MAC_ACC_SATURATE_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   function automatic logic lane_ovf(input logic signed [ACC_W-1:0] a,
                                     input logic signed [ACC_W-1:0] b);
      logic [ACC_W:0] s;
      s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      return s[ACC_W] != s[ACC_W-1];
   endfunction

   function automatic logic signed [ACC_W-1:0] lane_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W-1:0] b);
      logic [ACC_W:0] s;
      s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      if (s[ACC_W] != s[ACC_W-1])
         return s[ACC_W] ? ACC_MIN : ACC_MAX;
      return s[ACC_W-1:0];
   endfunction
`else
   function automatic logic signed [ACC_W-1:0] lane_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W-1:0] b);
      return a + b;
   endfunction
`endif

   assign accept    = in_valid && rdy_r;
   assign in_ready  = rdy_r;
   assign out_valid = ovld_r;
   // The first beat of a vector picks the mode straight from prec; later beats use the latched copy.
   assign eff_mode  = (state == IDLE) ? prec : mode_r;

   always_comb begin
      act_x = ACC_W'(act);
      wf    = ACC_W'($signed(wgt));
      for (int k = 0; k < 2; k++) wh[k] = ACC_W'($signed(wgt[k*HW +: HW]));
      for (int k = 0; k < 4; k++) wq[k] = ACC_W'($signed(wgt[k*QW +: QW]));
      for (int k = 0; k < 4; k++) prod_c[k] = '0;
      case (eff_mode)
         2'b01:   for (int k = 0; k < 2; k++) prod_c[k] = act_x * wh[k];
         2'b10:   for (int k = 0; k < 4; k++) prod_c[k] = act_x * wq[k];
         default: prod_c[0] = act_x * wf;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= IDLE;
         mode_r <= 2'b00;
         rdy_r  <= 1'b0;
         ovld_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               rdy_r <= !(accept && in_last);
               if (accept) begin
                  mode_r <= prec;
                  state  <= in_last ? DRAIN : ACC;
               end
            end
            ACC: begin
               if (accept && in_last) begin
                  state <= DRAIN;
                  rdy_r <= 1'b0;
               end
            end
            DRAIN: begin
               state  <= OUT;
               ovld_r <= 1'b1;
            end
            OUT: begin
               if (out_ready) begin
                  state  <= IDLE;
                  ovld_r <= 1'b0;
                  rdy_r  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stage 1: lane products registered on the acceptance edge
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_p1 <= 1'b0;
         for (int k = 0; k < 4; k++) prod_p1[k] <= '0;
      end else begin
         vld_p1 <= accept;
         for (int k = 0; k < 4; k++) prod_p1[k] <= accept ? prod_c[k] : '0;
      end
   end

   // Stage 2: per-lane accumulation, cleared on the result handshake
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < 4; k++) acc_p2[k] <= '0;
      end else if (ovld_r && out_ready) begin
         for (int k = 0; k < 4; k++) acc_p2[k] <= '0;
      end else if (vld_p1) begin
         for (int k = 0; k < 4; k++) acc_p2[k] <= lane_add(acc_p2[k], prod_p1[k]);
      end
   end

`ifdef SCALABLE_MAC_ACC_SATURATE_EN
   logic ovf_r;
   logic ovf_c;

   always_comb begin
      ovf_c = 1'b0;
      for (int k = 0; k < 4; k++) ovf_c = ovf_c | lane_ovf(acc_p2[k], prod_p1[k]);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                  ovf_r <= 1'b0;
      else if (ovld_r && out_ready) ovf_r <= 1'b0;
      else if (vld_p1 && ovf_c)   ovf_r <= 1'b1;
   end

   assign ovf = ovf_r;
`else
   assign ovf = 1'b0;
`endif

   always_comb begin
      result = '0;
      for (int k = 0; k < 4; k++) result[k*ACC_W +: ACC_W] = acc_p2[k];
   end
endmodule

// File: tb/tb_scalable_mac_acc.sv
// tb_scalable_mac_acc: randomized and directed checks of scalable_mac_acc against an arithmetic lane model.
module tb_scalable_mac_acc;
   localparam int ACT_W = 8;
   localparam int WGT_W = 8;
   localparam int ACC_W = 20;

   logic                    clk = 1'b0;
   logic                    rstn = 1'b0;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic                    in_last = 1'b0;
   logic [1:0]              prec = 2'b00;
   logic signed [ACT_W-1:0] act = '0;
   logic [WGT_W-1:0]        wgt = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic [4*ACC_W-1:0]      result;
   logic                    ovf;

   scalable_mac_acc #(.ACT_W(ACT_W), .WGT_W(WGT_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .prec(prec), .act(act), .wgt(wgt), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int     total = 0;
   int     bad = 0;
   int     gap_max = 0;
   int     va [64];
   int     vw [64];
   int     vp [64];
   longint m_lane [4];
   bit     m_ovf;
   int     m_mode;
   bit     m_first = 1'b1;
   longint e_lane [4];
   bit     e_ovf;
   bit     e_ready = 1'b0;

   task automatic check(input string name, input longint got, input longint want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic longint sval(input longint bits, input int n);
      longint b;
      b = bits & ((longint'(1) << n) - 1);
      if (b >= (longint'(1) << (n-1))) b -= (longint'(1) << n);
      return b;
   endfunction

   // Bring an exact sum into the accumulator's range: clamp when saturating, else modulo 2^ACC_W.
   function automatic longint fit(input longint v, output bit o);
      longint lim;
      longint r;
      lim = longint'(1) << (ACC_W-1);
      o = 1'b0;
      r = v;
`ifdef SCALABLE_MAC_ACC_SATURATE_EN
      if (v > lim - 1) begin o = 1'b1; r = lim - 1; end
      if (v < -lim)    begin o = 1'b1; r = -lim;    end
`else
      r = v % (2*lim);
      if (r < 0) r += 2*lim;
      if (r >= lim) r -= 2*lim;
`endif
      return r;
   endfunction

   function automatic longint lane(input int k);
      logic signed [ACC_W-1:0] t;
      t = result[k*ACC_W +: ACC_W];
      return longint'(t);
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 4; k++) m_lane[k] = 0;
      m_ovf = 1'b0;
      m_first = 1'b1;
   endtask

   task automatic model_beat(input int a, input int w, input int p, input bit last);
      longint sa;
      longint pr;
      bit     o;
      int     lanes;
      int     sw;
      if (m_first) m_mode = (p == 3) ? 0 : p;
      m_first = 1'b0;
      sa = sval(a, ACT_W);
      lanes = (m_mode == 0) ? 1 : (m_mode == 1) ? 2 : 4;
      sw = WGT_W / lanes;
      for (int k = 0; k < 4; k++) begin
         pr = (k < lanes) ? sa * sval(longint'(w) >> (k*sw), sw) : 0;
         m_lane[k] = fit(m_lane[k] + pr, o);
         m_ovf = m_ovf | o;
      end
      if (last) begin
         for (int k = 0; k < 4; k++) e_lane[k] = m_lane[k];
         e_ovf = m_ovf;
         e_ready = 1'b1;
         model_clear();
      end
   endtask

   always @(negedge clk) begin
      if (rstn && out_valid) begin
         if (!e_ready) begin
            check("unexpected out_valid", 1, 0);
         end else begin
            for (int k = 0; k < 4; k++) check($sformatf("model lane%0d", k), lane(k), e_lane[k]);
            check("model ovf", ovf, e_ovf);
            check("in_ready low in OUT", in_ready, 0);
         end
      end
   end

   task automatic send_vec(input int n, input bit close);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, gap_max)) begin
            in_valid = 1'b0;
            act = ACT_W'($urandom);
            wgt = WGT_W'($urandom);
            prec = 2'($urandom_range(0, 3));
            in_last = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
         check("in_ready before beat", in_ready, 1);
         in_valid = 1'b1;
         act = ACT_W'(va[i]);
         wgt = WGT_W'(vw[i]);
         prec = 2'(vp[i]);
         in_last = close && (i == n-1);
         @(posedge clk);
         model_beat(va[i], vw[i], vp[i], close && (i == n-1));
         @(negedge clk);
         in_valid = 1'b0;
         in_last = 1'b0;
      end
      if (close) begin
         check("out_valid one edge after last", out_valid, 0);
         check("in_ready in drain", in_ready, 0);
         @(negedge clk);
         check("out_valid two edges after last", out_valid, 1);
      end
   endtask

   task automatic release_vec(input int hold);
      logic [4*ACC_W-1:0] r0;
      out_ready = 1'b0;
      r0 = result;
      repeat (hold) begin
         @(negedge clk);
         check("out_valid held", out_valid, 1);
         check("in_ready held low", in_ready, 0);
         check("result stable", longint'(result == r0), 1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      e_ready = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid after handshake", out_valid, 0);
      check("in_ready after handshake", in_ready, 1);
      check("result cleared", longint'(result == '0), 1);
      check("ovf cleared", ovf, 0);
   endtask

   task automatic check_lit(input string name, input longint l0, input longint l1,
                            input longint l2, input longint l3, input longint o);
      check({name, " lane0"}, lane(0), l0);
      check({name, " lane1"}, lane(1), l1);
      check({name, " lane2"}, lane(2), l2);
      check({name, " lane3"}, lane(3), l3);
      check({name, " ovf"}, ovf, o);
   endtask

   task automatic reset_outputs_check(input string name);
      #1;
      check({name, " out_valid"}, out_valid, 0);
      check({name, " in_ready"}, in_ready, 0);
      check({name, " result"}, longint'(result == '0), 1);
      check({name, " ovf"}, ovf, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      reset_outputs_check("reset");
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("in_ready after reset", in_ready, 1);

      // Two-beat full-precision vector
      va[0] = -3; vw[0] = 5;  vp[0] = 0;
      va[1] = 7;  vw[1] = -2; vp[1] = 0;
      send_vec(2, 1);
      check_lit("m00", -29, 0, 0, 0, 0);
      check("m00 raw lane0", longint'(result[ACC_W-1:0]), 20'hFFFE3);
      release_vec(5);

      // One-beat quad-precision vector
      va[0] = 10; vw[0] = 8'b01_10_11_00; vp[0] = 2;
      send_vec(1, 1);
      check_lit("m10", 0, -10, -20, 10, 0);
      release_vec(1);

      // Mode 01 with prec changed mid-vector
      va[0] = 5;  vw[0] = 8'h12; vp[0] = 1;
      va[1] = -4; vw[1] = 8'hF3; vp[1] = 2;
      va[2] = 3;  vw[2] = 8'h7F; vp[2] = 2;
      gap_max = 2;
      send_vec(3, 1);
      check_lit("m01", -5, 30, 0, 0, 0);
      release_vec(0);

      // Overflow boundary: 32 x 16384 = 2^19
      gap_max = 0;
      for (int i = 0; i < 32; i++) begin va[i] = -128; vw[i] = -128; vp[i] = 0; end
      send_vec(32, 1);
`ifdef SCALABLE_MAC_ACC_SATURATE_EN
      check_lit("ovf32", 524287, 0, 0, 0, 1);
`else
      check_lit("ovf32", -524288, 0, 0, 0, 0);
      check("ovf32 raw lane0", longint'(result[ACC_W-1:0]), 20'h80000);
`endif
      release_vec(2);

      // Reset in the middle of a vector
      for (int i = 0; i < 3; i++) begin va[i] = 2; vw[i] = 3; vp[i] = 0; end
      send_vec(3, 0);
      @(negedge clk);
      check("partial lane0", lane(0), m_lane[0]);
      check("partial lane0 literal", lane(0), 18);
      #2 rstn = 1'b0;
      reset_outputs_check("mid reset");
      model_clear();
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("in_ready after mid reset", in_ready, 1);
      va[0] = 2; vw[0] = 3; vp[0] = 0;
      send_vec(1, 1);
      check_lit("after reset", 6, 0, 0, 0, 0);
      release_vec(1);

      // Reset while holding a result
      va[0] = 9; vw[0] = 9; vp[0] = 0;
      send_vec(1, 1);
      #2 rstn = 1'b0;
      reset_outputs_check("OUT reset");
      e_ready = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("in_ready after OUT reset", in_ready, 1);

      // Randomized vectors in all precision modes
      gap_max = 3;
      for (int v = 0; v < 40; v++) begin
         int n;
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) begin
            va[i] = int'($urandom_range(0, 255));
            vw[i] = int'($urandom_range(0, 255));
            vp[i] = int'($urandom_range(0, 3));
         end
         send_vec(n, 1);
         release_vec($urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
